chip8_mem_arbiter: RTL and testbench

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

---
 rtl/chip8_pkg.sv | 25 ++
 rtl/chip8_rr_arb2.sv | 39 +++
 rtl/chip8_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared widths and enumerations for the CHIP-8 memory arbiter and its helpers.
// Imported by the arbiter top level.
package chip8_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic {
        BOOT,
        RUN
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LD,
        REQ_CPU,
        REQ_DSP
    } req_id_t;

    // True when the granted requester expects a read result on the next cycle.
    function automatic logic id_returns_data(input req_id_t id, input logic cpu_we);
        return (id == REQ_DSP) || ((id == REQ_CPU) && !cpu_we);
    endfunction

endpackage

// File: rtl/chip8_rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-winner pointer.
// Grants are combinational; the pointer only moves when a grant is issued.
module chip8_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently; reset value favours index 0.
    logic last_reg;
    logic last_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = en & req[gi] & (~req[1-gi] | (last_reg != 1'(gi)));
        end
    endgenerate

    always_comb begin
        last_next = last_reg;
        if (gnt[1]) begin
            last_next = 1'b1;
        end else if (gnt[0]) begin
            last_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter: boot loader owns memory until ld_done, then the CPU
// and display share it round-robin. Grants and mem_* are combinational.
module chip8_mem_arbiter
    import chip8_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    output logic              dsp_gnt,
    output logic              dsp_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    req_id_t           grant_id;
    logic              run_en;
    logic [1:0]        rr_req;
    logic [1:0]        rr_gnt;
    logic              cpu_rvalid_reg;
    logic              dsp_rvalid_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    always_comb begin
        state_next = state_reg;
        if ((state_reg == BOOT) && ld_done) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grants are also masked by reset_n so nothing is granted while reset is held.
    assign run_en = reset_n && (state_reg == RUN);
    assign rr_req = {dsp_req, cpu_req};

    chip8_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_en),
        .req     (rr_req),
        .gnt     (rr_gnt)
    );

    always_comb begin
        grant_id = REQ_NONE;
        if (reset_n) begin
            if (state_reg == BOOT) begin
                if (ld_req) begin
                    grant_id = REQ_LD;
                end
            end else if (rr_gnt[0]) begin
                grant_id = REQ_CPU;
            end else if (rr_gnt[1]) begin
                grant_id = REQ_DSP;
            end
        end
    end

    // Without a grant the RAM port keeps its last address/data and never writes.
    always_comb begin
        mem_addr  = mem_addr_reg;
        mem_wdata = mem_wdata_reg;
        mem_we    = 1'b0;
        case (grant_id)
            REQ_LD: begin
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
                mem_we    = 1'b1;
            end
            REQ_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            REQ_DSP: begin
                mem_addr  = dsp_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_rvalid_reg <= 1'b0;
            dsp_rvalid_reg <= 1'b0;
        end else begin
            mem_addr_reg   <= mem_addr;
            mem_wdata_reg  <= mem_wdata;
            cpu_rvalid_reg <= (grant_id == REQ_CPU) && id_returns_data(grant_id, cpu_we);
            dsp_rvalid_reg <= (grant_id == REQ_DSP) && id_returns_data(grant_id, cpu_we);
        end
    end

    assign ld_gnt     = (grant_id == REQ_LD);
    assign cpu_gnt    = (grant_id == REQ_CPU);
    assign dsp_gnt    = (grant_id == REQ_DSP);
    assign cpu_rvalid = cpu_rvalid_reg;
    assign dsp_rvalid = dsp_rvalid_reg;
    assign cpu_run    = (state_reg == RUN);
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed vector table, hand-written corner sequences
// and random traffic, all checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_req, ld_done, ld_gnt;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dsp_req, dsp_gnt, dsp_rvalid;
    logic [11:0] dsp_addr;
    logic [7:0]  rdata;
    logic        cpu_run;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_done    (ld_done),
        .ld_gnt     (ld_gnt),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dsp_req    (dsp_req),
        .dsp_addr   (dsp_addr),
        .dsp_gnt    (dsp_gnt),
        .dsp_rvalid (dsp_rvalid),
        .rdata      (rdata),
        .cpu_run    (cpu_run),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port RAM behind the arbiter: one-cycle read latency.
    logic [7:0] ram [4096];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    typedef struct packed {
        logic        rst;
        logic        ld_req;
        logic [11:0] ld_addr;
        logic [7:0]  ld_wdata;
        logic        ld_done;
        logic        cpu_req;
        logic        cpu_we;
        logic [11:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        dsp_req;
        logic [11:0] dsp_addr;
    } stim_t;

    // exp order: {ld_gnt, cpu_gnt, dsp_gnt, cpu_rvalid, dsp_rvalid, mem_we, cpu_run}
    typedef struct packed {
        stim_t      s;
        logic [6:0] exp;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory image, mode, tie-break preference, outstanding read.
    logic [7:0]  ref_mem [4096];
    bit          m_run;
    bit          m_cpu_wins_tie;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    int          m_pend;       // 0 none, 1 cpu read, 2 display read
    logic [7:0]  m_pend_data;
    logic        g_ld, g_cpu, g_dsp;
    logic [6:0]  act;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run          = 1'b0;
        m_cpu_wins_tie = 1'b1;
        m_addr         = 12'h000;
        m_wdata        = 8'h00;
        m_pend         = 0;
        m_pend_data    = 8'h00;
    endtask

    function automatic stim_t mk(input logic rst, input logic lr, input logic [11:0] la,
                                 input logic [7:0] ldat, input logic done, input logic cr,
                                 input logic cwe, input logic [11:0] ca, input logic [7:0] cd,
                                 input logic dr, input logic [11:0] da);
        stim_t s;
        s.rst = rst;  s.ld_req = lr;  s.ld_addr = la;  s.ld_wdata = ldat;  s.ld_done = done;
        s.cpu_req = cr;  s.cpu_we = cwe;  s.cpu_addr = ca;  s.cpu_wdata = cd;
        s.dsp_req = dr;  s.dsp_addr = da;
        return s;
    endfunction

    function automatic vec_t v(input stim_t s, input logic [6:0] e, input logic c, input logic [7:0] r);
        vec_t x;
        x.s = s;  x.exp = e;  x.chk_rd = c;  x.exp_rd = r;
        return x;
    endfunction

    // One clock cycle: drive at the falling edge, compare after settling, advance the model.
    task automatic run_cycle(input stim_t s);
        logic        e_ld, e_cpu, e_dsp, e_we, e_crv, e_drv, e_run;
        logic [11:0] e_addr;
        logic [7:0]  e_wd, e_rd;
        @(negedge clk);
        reset_n   = ~s.rst;
        ld_req    = s.ld_req;   ld_addr  = s.ld_addr;  ld_wdata  = s.ld_wdata;  ld_done = s.ld_done;
        cpu_req   = s.cpu_req;  cpu_we   = s.cpu_we;   cpu_addr  = s.cpu_addr;  cpu_wdata = s.cpu_wdata;
        dsp_req   = s.dsp_req;  dsp_addr = s.dsp_addr;
        #1;
        act = {ld_gnt, cpu_gnt, dsp_gnt, cpu_rvalid, dsp_rvalid, mem_we, cpu_run};

        e_ld = 0; e_cpu = 0; e_dsp = 0; e_we = 0;
        e_addr = m_addr; e_wd = m_wdata;
        e_crv = (m_pend == 1); e_drv = (m_pend == 2); e_rd = m_pend_data; e_run = m_run;
        if (s.rst) begin
            e_crv = 0; e_drv = 0; e_run = 0; e_addr = 12'h000; e_wd = 8'h00;
        end else if (!m_run) begin
            if (s.ld_req) begin
                e_ld = 1; e_we = 1; e_addr = s.ld_addr; e_wd = s.ld_wdata;
            end
        end else begin
            if (s.cpu_req && s.dsp_req) begin
                e_cpu = m_cpu_wins_tie;
                e_dsp = !m_cpu_wins_tie;
            end else begin
                e_cpu = s.cpu_req;
                e_dsp = s.dsp_req;
            end
            if (e_cpu) begin
                e_addr = s.cpu_addr; e_wd = s.cpu_wdata; e_we = s.cpu_we;
            end
            if (e_dsp) e_addr = s.dsp_addr;
        end

        check("ld_gnt", ld_gnt, e_ld);
        check("cpu_gnt", cpu_gnt, e_cpu);
        check("dsp_gnt", dsp_gnt, e_dsp);
        check("cpu_rvalid", cpu_rvalid, e_crv);
        check("dsp_rvalid", dsp_rvalid, e_drv);
        check("cpu_run", cpu_run, e_run);
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        if (e_we || s.rst) check("mem_wdata", mem_wdata, e_wd);
        if (e_crv || e_drv) check("rdata", rdata, e_rd);

        $display("t=%0t rst=%b ld_gnt=%b cpu_gnt=%b dsp_gnt=%b we=%b addr=%03h wd=%02h crv=%b drv=%b rd=%02h run=%b",
                 $time, s.rst, ld_gnt, cpu_gnt, dsp_gnt, mem_we, mem_addr, mem_wdata,
                 cpu_rvalid, dsp_rvalid, rdata, cpu_run);

        g_ld = e_ld; g_cpu = e_cpu; g_dsp = e_dsp;
        if (s.rst) begin
            model_reset();
        end else begin
            if (e_we) ref_mem[e_addr] = e_wd;
            m_pend = 0;
            if (e_cpu && !s.cpu_we) begin m_pend = 1; m_pend_data = ref_mem[e_addr]; end
            if (e_dsp)              begin m_pend = 2; m_pend_data = ref_mem[e_addr]; end
            if (e_cpu) m_cpu_wins_tie = 1'b0;
            if (e_dsp) m_cpu_wins_tie = 1'b1;
            if (!m_run && s.ld_done) m_run = 1'b1;
            m_addr = e_addr; m_wdata = e_wd;
        end
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 12'hFF0 + 12'($urandom_range(0, 15));
        return 12'($urandom_range(0, 15));
    endfunction

    vec_t  tbl[$];
    stim_t z;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        model_reset();
        reset_n = 1'b1;
        ld_req = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dsp_req = 0; dsp_addr = 0;
        #1;

        //            rst ldr  ld_addr  ld_d  done cr cwe cpu_addr cpu_d  dr dsp_addr
        tbl.push_back(v(mk(1, 1, 12'h123, 8'h45, 0, 1, 1, 12'h010, 8'h11, 1, 12'h020), 7'b0000000, 0, 8'h00));
        tbl.push_back(v(mk(1, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0000000, 0, 8'h00));
        tbl.push_back(v(mk(0, 1, 12'h200, 8'h00, 0, 1, 0, 12'h200, 8'h00, 0, 12'h000), 7'b1000010, 0, 8'h00));
        tbl.push_back(v(mk(0, 1, 12'h201, 8'hE0, 0, 1, 0, 12'h200, 8'h00, 0, 12'h000), 7'b1000010, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 1, 1, 0, 12'h200, 8'h00, 0, 12'h000), 7'b0000000, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h200, 8'h00, 0, 12'h000), 7'b0100001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0001001, 1, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 1, 12'h300, 8'hA5, 0, 12'h000), 7'b0100011, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 1, 12'h300), 7'b0010001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0000101, 1, 8'hA5));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h201, 8'h00, 1, 12'h200), 7'b0100001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h300, 8'h00, 1, 12'h200), 7'b0011001, 1, 8'hE0));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0000101, 1, 8'h00));
        tbl.push_back(v(mk(0, 1, 12'h000, 8'h55, 1, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0000001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0100001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0001001, 1, 8'h00));
        // Loader write and ld_done together at the top address.
        tbl.push_back(v(mk(1, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0000000, 0, 8'h00));
        tbl.push_back(v(mk(0, 1, 12'hFFF, 8'h12, 1, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b1000010, 0, 8'h00));
        tbl.push_back(v(mk(0, 1, 12'h100, 8'h77, 0, 1, 0, 12'hFFF, 8'h00, 0, 12'h000), 7'b0100001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0001001, 1, 8'h12));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 1, 0, 12'h100, 8'h00, 0, 12'h000), 7'b0100001, 0, 8'h00));
        tbl.push_back(v(mk(0, 0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000), 7'b0001001, 1, 8'h00));

        foreach (tbl[i]) begin
            run_cycle(tbl[i].s);
            check($sformatf("vec%0d_outs", i), act, tbl[i].exp);
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
        end

        // Continuous CPU+display requests right after reset alternate, CPU first.
        z = '0;
        run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            run_cycle(mk(0, 0, 0, 0, 0, 1, 0, 12'h010, 8'h00, 1, 12'h020));
            check("alt_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("alt_dsp_gnt", dsp_gnt, (i % 2) == 1);
        end

        // Reset asserted before the edge that would raise cpu_rvalid.
        run_cycle(mk(0, 0, 0, 0, 0, 1, 0, 12'h201, 8'h00, 0, 0));
        check("midrst_gnt_before", cpu_gnt, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_gnt_during", cpu_gnt, 1'b0);
        model_reset();
        run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            run_cycle(z);
            check("midrst_rvalid", cpu_rvalid, 1'b0);
            check("midrst_run", cpu_run, 1'b0);
        end

        // Random traffic: requesters hold until granted, may drop, occasional reset.
        begin
            logic        cr, cwe, dr, lr, done, rst;
            logic [11:0] ca, da, la;
            logic [7:0]  cd, ldat;
            cr = 0; cwe = 0; ca = 0; cd = 0; dr = 0; da = 0; lr = 0; la = 0; ldat = 0;
            for (int n = 0; n < 400; n++) begin
                if (!cr) begin
                    if ($urandom_range(0, 1) == 1) begin
                        cr = 1; cwe = 1'($urandom_range(0, 1)); ca = rand_addr(); cd = 8'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) cr = 0;
                if (!dr) begin
                    if ($urandom_range(0, 1) == 1) begin dr = 1; da = rand_addr(); end
                end else if ($urandom_range(0, 7) == 0) dr = 0;
                if (!lr && $urandom_range(0, 2) != 0) begin
                    lr = 1; la = rand_addr(); ldat = 8'($urandom);
                end
                done = !m_run && ($urandom_range(0, 9) == 0);
                rst  = ($urandom_range(0, 99) == 0);
                run_cycle(mk(rst, lr, la, ldat, done, cr, cwe, ca, cd, dr, da));
                if (g_cpu) cr = 0;
                if (g_dsp) dr = 0;
                if (g_ld || m_run) lr = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
